// File: rtl/tile_block_writer.sv
// tile_block_writer: fills a TILE_W x TILE_H block of background RAM, row-major with edge clipping.
// Define TILE_WALL_PRESERVE_EN to read each pixel first and leave colour-0 wall pixels untouched.
module tile_block_writer #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int TILE_W = 4,
  parameter int TILE_H = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [8:0]  req_x,
  input  logic [8:0]  req_y,
  input  logic [11:0] req_clr,
  output logic [16:0] wr_address,
  output logic [11:0] wr_data,
  output logic        wr_en,
  output logic        busy,
  output logic        done
`ifdef TILE_WALL_PRESERVE_EN
  ,
  output logic [16:0] rd_address,
  input  logic [11:0] rd_q
`endif
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [8:0] x_q, x_d, y_q, y_d, bx, by;
  logic [11:0] clr_q, clr_d, wr_data_q, wr_data_d;
  logic [3:0] dx_q, dx_d, dy_q, dy_d, cx, cy;
  logic [16:0] wr_address_q, wr_address_d, addr;
  logic [9:0] px, py;
  logic req_ready_q, req_ready_d, wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;
  logic idle, row_end, last, in_b;
`ifdef TILE_WALL_PRESERVE_EN
  logic [1:0] ph_q, ph_d;
  logic [16:0] rd_address_q, rd_address_d;
  assign rd_address = rd_address_q;
`endif
  assign req_ready = req_ready_q;
  assign wr_address = wr_address_q;
  assign wr_data = wr_data_q;
  assign wr_en = wr_en_q;
  assign busy = busy_q;
  assign done = done_q;
  // Counters track the pixel currently on the outputs; cx/cy select the one to emit next.
  always_comb begin
    idle = state_q == IDLE;
    row_end = dx_q == 4'(TILE_W - 1);
    last = row_end && dy_q == 4'(TILE_H - 1);
    bx = idle ? req_x : x_q;
    by = idle ? req_y : y_q;
`ifdef TILE_WALL_PRESERVE_EN
    cx = idle ? 4'd0 : (ph_q == 2'd1) ? dx_q : row_end ? 4'd0 : dx_q + 4'd1;
    cy = idle ? 4'd0 : (ph_q == 2'd1) ? dy_q : row_end ? dy_q + 4'd1 : dy_q;
`else
    cx = idle ? 4'd0 : row_end ? 4'd0 : dx_q + 4'd1;
    cy = idle ? 4'd0 : row_end ? dy_q + 4'd1 : dy_q;
`endif
    px = {1'b0, bx} + {6'd0, cx};
    py = {1'b0, by} + {6'd0, cy};
    addr = 17'(py) * 17'(SCREEN_W) + 17'(px);
    in_b = px < 10'(SCREEN_W) && py < 10'(SCREEN_H);
  end
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    clr_d = clr_q;
    dx_d = dx_q;
    dy_d = dy_q;
    req_ready_d = req_ready_q;
    busy_d = busy_q;
    done_d = 1'b0;
    wr_en_d = 1'b0;
    wr_address_d = wr_address_q;
    wr_data_d = wr_data_q;
`ifdef TILE_WALL_PRESERVE_EN
    ph_d = ph_q;
    rd_address_d = rd_address_q;
`endif
    if (state_q == IDLE) begin
      if (req_valid) begin
        state_d = WRITE;
        x_d = req_x;
        y_d = req_y;
        clr_d = req_clr;
        dx_d = 4'd0;
        dy_d = 4'd0;
        busy_d = 1'b1;
        req_ready_d = 1'b0;
`ifdef TILE_WALL_PRESERVE_EN
        ph_d = 2'd0;
        rd_address_d = addr;
`else
        wr_en_d = in_b;
        wr_address_d = addr;
        wr_data_d = req_clr;
`endif
      end
    end else if (state_q == WRITE) begin
`ifdef TILE_WALL_PRESERVE_EN
      if (ph_q == 2'd0) begin
        ph_d = 2'd1;
      end else if (ph_q == 2'd1) begin
        ph_d = 2'd2;
        wr_en_d = in_b && rd_q != 12'd0;
        wr_address_d = addr;
        wr_data_d = clr_q;
      end else if (last) begin
        state_d = DONE;
        done_d = 1'b1;
      end else begin
        ph_d = 2'd0;
        dx_d = cx;
        dy_d = cy;
        rd_address_d = addr;
      end
`else
      if (last) begin
        state_d = DONE;
        done_d = 1'b1;
      end else begin
        dx_d = cx;
        dy_d = cy;
        wr_en_d = in_b;
        wr_address_d = addr;
        wr_data_d = clr_q;
      end
`endif
    end else begin
      state_d = IDLE;
      busy_d = 1'b0;
      req_ready_d = 1'b1;
      dx_d = 4'd0;
      dy_d = 4'd0;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      clr_q <= '0;
      dx_q <= '0;
      dy_q <= '0;
      req_ready_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      wr_en_q <= 1'b0;
      wr_address_q <= '0;
      wr_data_q <= '0;
`ifdef TILE_WALL_PRESERVE_EN
      ph_q <= '0;
      rd_address_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      clr_q <= clr_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      req_ready_q <= req_ready_d;
      busy_q <= busy_d;
      done_q <= done_d;
      wr_en_q <= wr_en_d;
      wr_address_q <= wr_address_d;
      wr_data_q <= wr_data_d;
`ifdef TILE_WALL_PRESERVE_EN
      ph_q <= ph_d;
      rd_address_q <= rd_address_d;
`endif
    end
  end
endmodule

// File: tb/tb_tile_block_writer.sv
// tb_tile_block_writer: vector table plus hold-off and mid-block reset sequences, writes checked via scoreboard.
module tb_tile_block_writer;
`ifdef TILE_WALL_PRESERVE_EN
  localparam int PPC = 3;
  localparam bit PRES = 1'b1;
`else
  localparam int PPC = 1;
  localparam bit PRES = 1'b0;
`endif
  localparam int N = 16;
  localparam int DC = PPC * N + 1;
  localparam int RC = PPC * N + 2;
  typedef struct {
    int x;
    int y;
    logic [11:0] clr;
    int n;
  } vec_t;
  logic clk = 1'b0, resetn = 1'b0, req_valid = 1'b0;
  logic [8:0] req_x = '0, req_y = '0;
  logic [11:0] req_clr = '0;
  logic req_ready, wr_en, busy, done;
  logic [16:0] wr_address;
  logic [11:0] wr_data;
  int n_cmp = 0, n_bad = 0, n_wr = 0, n_done = 0;
  logic [28:0] sb[$];
  vec_t tab[7];
  always #5 clk = ~clk;
`ifdef TILE_WALL_PRESERVE_EN
  logic [16:0] rd_address;
  logic [11:0] rd_q;
  always @(posedge clk) rd_q <= (rd_address == 17'd1611) ? 12'h000 : 12'h0F0;
`endif
  tile_block_writer dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_clr(req_clr), .wr_address(wr_address),
    .wr_data(wr_data), .wr_en(wr_en), .busy(busy), .done(done)
`ifdef TILE_WALL_PRESERVE_EN
    , .rd_address(rd_address), .rd_q(rd_q)
`endif
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic step();
    logic [28:0] e;
    @(negedge clk);
    if (done) begin
      n_done++;
      chk("no_write_in_done", {31'd0, wr_en}, 0);
    end
    if (wr_en) begin
      n_wr++;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %0d data %0h with empty scoreboard", wr_address, wr_data);
      end else begin
        e = sb.pop_front();
        chk("wr_address", {15'd0, wr_address}, {15'd0, e[28:12]});
        chk("wr_data", {20'd0, wr_data}, {20'd0, e[11:0]});
      end
    end
  endtask
  task automatic push_block(input int x, input int y, input logic [11:0] c);
    int px, py, a;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++) begin
        px = x + i;
        py = y + j;
        a = py * 320 + px;
        if (px < 320 && py < 240 && (!PRES || a != 1611)) sb.push_back({17'(a), c});
      end
  endtask
  task automatic run_vec(input vec_t v);
    int w, nw0, nd0, dcyc;
    w = 0;
    while (!req_ready && w < 100) begin
      step();
      w++;
    end
    chk("ready_before_req", {31'd0, req_ready}, 1);
    push_block(v.x, v.y, v.clr);
    req_x = 9'(v.x);
    req_y = 9'(v.y);
    req_clr = v.clr;
    req_valid = 1'b1;
    nw0 = n_wr;
    nd0 = n_done;
    dcyc = -1;
    for (int c = 1; c <= RC; c++) begin
      step();
      if (c == 1) begin
        req_valid = 1'b0;
        req_x = 9'h1FF;
        req_y = 9'h0AA;
        req_clr = 12'h000;
        chk("busy_after_accept", {31'd0, busy}, 1);
        chk("ready_low_after_accept", {31'd0, req_ready}, 0);
      end
      if (done && dcyc < 0) dcyc = c;
    end
    chk("done_cycle", dcyc, DC);
    chk("done_count", n_done - nd0, 1);
    chk("write_count", n_wr - nw0, v.n);
    chk("ready_after_done", {31'd0, req_ready}, 1);
    chk("busy_after_done", {31'd0, busy}, 0);
    chk("scoreboard_empty", sb.size(), 0);
  endtask
  initial begin
    int fb, d1, d2, nw0, nd0, c;
    tab[0] = '{10, 5, 12'hFFF, PRES ? 15 : 16};
    tab[1] = '{318, 238, 12'h0A5, 4};
    tab[2] = '{330, 0, 12'h123, 0};
    tab[3] = '{0, 0, 12'h3C3, 16};
    tab[4] = '{400, 300, 12'h0F0, 0};
    tab[5] = '{316, 100, 12'h9E1, 16};
    tab[6] = '{317, 0, 12'h246, 12};
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 1);
    chk("rst_wr_en", {31'd0, wr_en}, 0);
    chk("rst_wr_address", {15'd0, wr_address}, 0);
    chk("rst_wr_data", {20'd0, wr_data}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    resetn = 1'b1;
    for (int k = 0; k < 7; k++) run_vec(tab[k]);
    // second request held from cycle 3 must wait for the first block to finish
    push_block(10, 5, 12'h5A5);
    req_x = 9'd10;
    req_y = 9'd5;
    req_clr = 12'h5A5;
    req_valid = 1'b1;
    fb = -1;
    d1 = -1;
    d2 = -1;
    for (int k = 1; k <= 2 * RC; k++) begin
      step();
      if (k == 1) req_valid = 1'b0;
      if (k == 3) begin
        push_block(20, 20, 12'h555);
        req_x = 9'd20;
        req_y = 9'd20;
        req_clr = 12'h555;
        req_valid = 1'b1;
      end
      if (k == RC - 1) chk("holdoff_ready_low", {31'd0, req_ready}, 0);
      if (k == RC) chk("holdoff_ready_high", {31'd0, req_ready}, 1);
      if (k == RC + 1) begin
        req_valid = 1'b0;
        req_x = 9'h1FF;
      end
      if (wr_en && wr_address == 17'd6420 && fb < 0) fb = k;
      if (done && d1 < 0) d1 = k;
      else if (done && d2 < 0) d2 = k;
    end
    chk("holdoff_first_write_cycle", fb, RC + PPC);
    chk("holdoff_done_a", d1, DC);
    chk("holdoff_done_b", d2, RC + DC);
    chk("holdoff_sb_empty", sb.size(), 0);
    push_block(50, 50, 12'h777);
    req_x = 9'd50;
    req_y = 9'd50;
    req_clr = 12'h777;
    req_valid = 1'b1;
    nw0 = n_wr;
    c = 0;
    while (n_wr - nw0 < 5 && c < 200) begin
      step();
      req_valid = 1'b0;
      c++;
    end
    chk("midrst_five_writes", n_wr - nw0, 5);
    resetn = 1'b0;
    #1;
    chk("midrst_wr_en", {31'd0, wr_en}, 0);
    chk("midrst_wr_address", {15'd0, wr_address}, 0);
    chk("midrst_wr_data", {20'd0, wr_data}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_done", {31'd0, done}, 0);
    chk("midrst_ready", {31'd0, req_ready}, 1);
    sb.delete();
    nd0 = n_done;
    repeat (3) step();
    resetn = 1'b1;
    repeat (PPC * N + 4) step();
    chk("midrst_no_done", n_done - nd0, 0);
    chk("midrst_ready_after", {31'd0, req_ready}, 1);
    run_vec(tab[0]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach summary");
    $fatal(1);
  end
endmodule

// File: doc/tile_block_writer.md
Name: tile_block_writer

Overview:
- Write-side companion to the background-ROM wall probes.
- Accepts a tile request (x, y, colour) over a valid/ready handshake and writes a TILE_W x TILE_H block of that colour into the 320x240, 12-bit background RAM.
- Writes one pixel per cycle, row-major, with screen-edge clipping.
- Used to erase eaten pellets and redraw floor, so that later wall probes read the updated maze.

Parameters:
- SCREEN_W, 320, pixels per row; address stride.
- SCREEN_H, 240, rows.
- TILE_W, 4, block width in pixels (1..16).
- TILE_H, 4, block height in pixels (1..16).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_x  in  9  top-left column.
- req_y  in  9  top-left row.
- req_clr  in  12  fill colour.
- wr_address  out  17  RAM write address.
- wr_data  out  12  RAM write data.
- wr_en  out  1  RAM write strobe.
- busy  out  1  request in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values: resetn=0 asynchronously forces the following, regardless of state.
  - State IDLE; req_ready=1.
  - wr_en=0, wr_address=0, wr_data=0.
  - busy=0, done=0; counters dx=dy=0.
- All outputs are registered.
- States: IDLE, WRITE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch x, y and clr at the edge; go to WRITE with dx=dy=0, busy=1, req_ready=0.
- WRITE:
  - Each cycle emits pixel (x+dx, y+dy): wr_address = SCREEN_W*(y+dy)+(x+dx), 17-bit; wr_data = latched clr.
  - wr_en=1 only if x+dx < SCREEN_W and y+dy < SCREEN_H. Compare at 10 bits; no wrap into the next row.
  - Clipped pixels still consume their cycle, so timing is fixed.
  - dx increments; at TILE_W-1 it resets to 0 and dy increments.
  - After pixel (TILE_W-1, TILE_H-1), go to DONE.
- DONE:
  - done=1 and wr_en=0 for exactly one cycle.
  - Next cycle: IDLE, busy=0, req_ready=1.
- Latency: acceptance edge at cycle 0.
  - Pixels are on wr_* during cycles 1..TILE_W*TILE_H.
  - done asserts in cycle TILE_W*TILE_H+1.
  - Next request can be accepted at cycle TILE_W*TILE_H+2.
- Handshake rules:
  - req_valid is ignored while req_ready=0; no queuing.
  - req_x, req_y and req_clr changes after acceptance have no effect.
- Reset mid-block: the block is abandoned. Pixels already written stay in RAM; no done pulse.
- Origin at or past the screen edge (e.g. req_x=400): every pixel is clipped, and full timing and the done pulse still occur.

Optional Feature:
- Macro: TILE_WALL_PRESERVE_EN.
- When defined:
  - Adds ports rd_address (out, 17) and rd_q (in, 12), connected to a read port of the same background memory. That port has 1-cycle registered latency.
  - Each pixel takes 3 cycles: RD, WAIT, WR.
    - RD drives rd_address = pixel address.
    - WAIT covers the memory latency.
    - WR writes the pixel only if the pixel is unclipped and rd_q != 0, which preserves wall pixels (colour 0).
  - done asserts in cycle 3*TILE_W*TILE_H+1.
  - rd_address resets to 0.
- When undefined:
  - The rd_* ports are absent.
  - Timing is 1 pixel per cycle as above.

Test Plan:
- Basic write: 4x4 request at x=10, y=5, clr=0xFFF, accepted at cycle 0 -> 16 writes, addresses 1610-1613, 1930-1933, 2250-2253, 2570-2573, data 0xFFF. done=1 exactly at cycle 17; req_ready=1 at cycle 18.
- Corner clipping: request at x=318, y=238 -> exactly 4 wr_en pulses at 76478, 76479, 76798, 76799. The other 12 cycles have wr_en=0; done still at cycle 17.
- Hold-off: second request (x=20, y=20) held valid from cycle 3 -> not accepted until cycle 18. Its first write is address 6420 at cycle 19; first block's data is unaffected.
- Reset mid-block: assert resetn=0 after the 5th write -> all outputs 0 immediately and no done pulse. After release, req_ready=1 and a new request completes normally.
- Fully off-screen: request at x=330, y=0 -> zero wr_en pulses; done at cycle 17.
- With TILE_WALL_PRESERVE_EN: model rd_q=0 at address 1611 and 0x0F0 elsewhere; 4x4 request at (10,5) -> 15 writes, 1611 skipped. done at cycle 49.
